gate_array_reducer: RTL and testbench
=====================================

# gate_array_reducer

Parametrised, clocked successor to the team's combinational gate-on-packed-array test blocks. Accepts CH channels of W-bit packed words per transaction and reduces each channel to one bit with a per-transaction selectable gate (NAND, XOR, NOR, or running XOR). It flags channels carrying X/Z bits and buffers the results in an output FIFO with valid/ready handshakes on both sides. It is a 4-state-aware stimulus/response block for the simulator regression suite.

## Interface
- CH, 4, number of channels (1..16)
- W, 12, bits per channel word (1..64)
- DEPTH, 2, output FIFO entries (power of two, 2..16)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  transaction present
- in_ready  output  1  block can accept this cycle
- in_data  input  [CH-1:0][W-1:0]  channel words, channel c = in_data[c]
- in_op  input  2  0 NAND-reduce, 1 XOR-reduce, 2 NOR-reduce, 3 accumulate-XOR
- acc_clear  input  1  synchronous clear of all accumulators
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head
- out_bit  output  [CH-1:0]  reduced result per channel
- out_xz  output  [CH-1:0]  channel input contained X or Z
- out_op  output  2  op of the head entry
- level  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Push/pop: accept = push; out_valid && out_ready = pop.
- Per channel c on accept:
  - xz[c] = 1 if any bit of in_data[c] is X or Z (reduction-XOR compared with === 1'bx).
  - If xz[c]: the pushed bit is 0, the pushed out_xz is 1, and acc[c] is unchanged.
  - Op 0: bit = ~&in_data[c].
  - Op 1: bit = ^in_data[c].
  - Op 2: bit = ~|in_data[c].
  - Op 3: acc[c] <= acc_base[c] ^ (^in_data[c]); the pushed bit is the new acc[c].
  - acc_base[c] is 0 when acc_clear is high in the same cycle, otherwise acc[c]. Clear is applied first, then the update.
- acc_clear without an op-3 accept zeroes all acc[c] and pushes nothing.
- Accumulators are touched only by accepted op-3 transactions and by acc_clear.
- FIFO:
  - Circular, DEPTH entries of {out_bit, out_xz, out_op}.
  - Read and write pointers each have one wrap bit.
  - Full = level == DEPTH; empty = level == 0.
  - in_ready = !full || out_ready. A full FIFO accepts when the head pops in the same cycle.
  - Push and pop in the same cycle leave level unchanged. This holds for any level, including full and, when empty, not applicable since out_valid = 0.
  - out_bit/out_xz/out_op always show the head entry. When empty they hold the last popped value, which is 0 after reset.
- in_valid while !in_ready: the transaction is not accepted and nothing changes. The source must hold its data stable until accepted.
- Widths: level saturates only by construction and never exceeds DEPTH. Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release on the next clk edge):
  - FIFO empty, level = 0, out_valid = 0.
  - out_bit = 0, out_xz = 0, out_op = 0.
  - All acc = 0.
  - in_ready = 1 during and after reset.
- Latency: a transaction accepted at edge N is visible at the FIFO head with out_valid = 1 after edge N, when the FIFO was empty. Otherwise it appears behind older entries.
- Throughput: one transaction per cycle when the consumer holds out_ready = 1.
- in_ready is combinational from level and out_ready. There is no combinational path from in_valid or in_data to any output.
- Reset mid-operation: all buffered entries and accumulators are lost, and outputs return to reset values immediately on rst_n falling.

## Test plan
- Reset, then push CH=4, W=12 with channel words 12'hFFF, 12'h000, 12'h001, 12'h003 and op 0 -> next cycle out_valid=1, out_bit=4'b1110 (ch0 → bit0), out_xz=0, level=1.
- With out_ready=0, push 3 transactions (DEPTH=2) -> in_ready falls after 2, level=2, the third is held. Raise out_ready -> the third is accepted on the pop cycle and level stays 2. Data order is preserved.
- Op 3 with ch0 words 12'h001, 12'h003, 12'h007 across three accepts -> ch0 out_bit sequence 1, 1, 0. Assert acc_clear with the fourth accept of 12'h001 -> bit 1.
- ch2 word 12'b0000_0000_0x01 with op 1 -> out_xz=4'b0100, out_bit[2]=0. With op 3, acc[2] is unchanged, checked by a following clean op-3 push.
- Assert rst_n low while level=2 and acc≠0 -> out_valid=0, level=0, outputs 0 at once. A clean op-3 push of 12'h001 after release yields out_bit[c]=1.
- Streaming 100 random transactions with random out_ready -> scoreboard matches every entry, there are no drops or duplicates, and level never exceeds DEPTH.

Source files
------------

// File: rtl/gate_array_reducer.sv
// Per-channel gate reduction (NAND/XOR/NOR/accumulate-XOR) with X/Z flagging,
// buffered through a circular output FIFO with valid/ready on both sides.
module gate_array_reducer #(
   parameter int unsigned CH    = 4,
   parameter int unsigned W     = 12,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CH-1:0][W-1:0]   in_data,
   input  logic [1:0]             in_op,
   input  logic                   acc_clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CH-1:0]          out_bit,
   output logic [CH-1:0]          out_xz,
   output logic [1:0]             out_op,
   output logic [$clog2(DEPTH):0] level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      OP_NAND = 2'd0,
      OP_XOR  = 2'd1,
      OP_NOR  = 2'd2,
      OP_ACC  = 2'd3
   } op_e;

   typedef struct packed {
      logic [CH-1:0] bits;
      logic [CH-1:0] xz;
      logic [1:0]    op;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          last_q;
   entry_t          new_entry;
   entry_t          head;
   logic [AW:0]     wr_q, rd_q;
   logic [CH-1:0]   acc_q, acc_d, acc_base;
   logic [CH-1:0]   par, xz;
   logic            full, empty, push, pop;

   assign empty     = (wr_q == rd_q);
   assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level     = wr_q - rd_q;
   assign in_ready  = !full || out_ready;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign acc_base  = acc_clear ? '0 : acc_q;

   always_comb begin
      for (int unsigned c = 0; c < CH; c++) begin
         par[c] = ^in_data[c];
         xz[c]  = ((^in_data[c]) === 1'bx);
      end
   end

   // Clear is folded into acc_base so a same-cycle op-3 accept builds on zero.
   always_comb begin
      acc_d          = acc_base;
      new_entry      = '0;
      new_entry.xz   = xz;
      new_entry.op   = in_op;
      for (int unsigned c = 0; c < CH; c++) begin
         if (!xz[c]) begin
            unique case (op_e'(in_op))
               OP_NAND: new_entry.bits[c] = ~&in_data[c];
               OP_XOR:  new_entry.bits[c] = par[c];
               OP_NOR:  new_entry.bits[c] = ~|in_data[c];
               OP_ACC: begin
                  new_entry.bits[c] = acc_base[c] ^ par[c];
                  if (push) acc_d[c] = new_entry.bits[c];
               end
            endcase
         end
      end
   end

   // When empty the outputs keep showing the most recently popped entry.
   assign head    = empty ? last_q : mem_q[rd_q[AW-1:0]];
   assign out_bit = head.bits;
   assign out_xz  = head.xz;
   assign out_op  = head.op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         acc_q  <= '0;
         last_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         acc_q <= acc_d;
         if (push) begin
            mem_q[wr_q[AW-1:0]] <= new_entry;
            wr_q                <= wr_q + PTR_ONE;
         end
         if (pop) begin
            last_q <= mem_q[rd_q[AW-1:0]];
            rd_q   <= rd_q + PTR_ONE;
         end
      end
   end
endmodule

// File: tb/tb_gate_array_reducer.sv
// Scoreboard bench for gate_array_reducer: expected entries are queued on
// accept and compared against the FIFO head when it is popped.
module tb_gate_array_reducer;
   localparam int unsigned CH    = 4;
   localparam int unsigned W     = 12;
   localparam int unsigned DEPTH = 2;

   typedef struct packed {
      logic [CH-1:0] bits;
      logic [CH-1:0] xz;
      logic [1:0]    op;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [CH-1:0][W-1:0]   in_data;
   logic [1:0]             in_op;
   logic                   acc_clear;
   logic                   out_valid;
   logic                   out_ready;
   logic [CH-1:0]          out_bit;
   logic [CH-1:0]          out_xz;
   logic [1:0]             out_op;
   logic [$clog2(DEPTH):0] level;

   ent_t          sb[$];
   logic [CH-1:0] model_acc;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_acc   = 0;

   gate_array_reducer #(.CH(CH), .W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_op(in_op), .acc_clear(acc_clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
      .out_xz(out_xz), .out_op(out_op), .level(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_push(input logic [CH-1:0][W-1:0] d, input logic [1:0] op, input logic clr);
      ent_t e;
      if (clr) model_acc = '0;
      e = '0;
      e.op = op;
      for (int c = 0; c < CH; c++) begin
         if ($isunknown(d[c])) e.xz[c] = 1'b1;
         else case (op)
            2'd0: e.bits[c] = (d[c] != {W{1'b1}});
            2'd1: e.bits[c] = (($countones(d[c]) % 2) == 1);
            2'd2: e.bits[c] = (d[c] == '0);
            default: begin
               model_acc[c] = model_acc[c] ^ (($countones(d[c]) % 2) == 1);
               e.bits[c]    = model_acc[c];
            end
         endcase
      end
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic cycle(input logic v, input logic [CH-1:0][W-1:0] d, input logic [1:0] op,
                        input logic clr, input logic ordy);
      ent_t h;
      logic exp_rdy, do_acc, do_pop;
      in_valid = v; in_data = d; in_op = op; acc_clear = clr; out_ready = ordy;
      #2;
      exp_rdy = (sb.size() < DEPTH) || ordy;
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, sb.size() != 0);
      do_acc = v && exp_rdy;
      do_pop = (sb.size() != 0) && ordy;
      if (sb.size() != 0) begin
         h = sb[0];
         check("head_bit", out_bit, h.bits);
         check("head_xz", out_xz, h.xz);
         check("head_op", out_op, h.op);
      end
      if (do_pop) h = sb.pop_front();
      if (do_acc) begin
         model_push(d, op, clr);
         n_acc++;
      end else if (clr) model_acc = '0;
      @(negedge clk);
      check("level", level, sb.size());
      check("level_le_depth", level <= DEPTH, 1);
   endtask

   logic [CH-1:0][W-1:0] d;

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = 2'd0;
      acc_clear = 1'b0; out_ready = 1'b0; model_acc = '0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_out_bit", out_bit, 0);
      check("rst_out_xz", out_xz, 0);
      check("rst_out_op", out_op, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Basic NAND push: ch0 -> bit0
      d[0] = 12'hFFF; d[1] = 12'h000; d[2] = 12'h001; d[3] = 12'h003;
      cycle(1, d, 2'd0, 0, 0);
      check("t1_out_valid", out_valid, 1);
      check("t1_out_bit", out_bit, 4'b1110);
      check("t1_out_xz", out_xz, 0);
      check("t1_level", level, 1);
      cycle(0, d, 2'd0, 0, 1);

      // Backpressure with DEPTH=2
      d[0] = 12'h00F; d[1] = 12'h0F0; d[2] = 12'hF00; d[3] = 12'h555;
      cycle(1, d, 2'd1, 0, 0);
      d[0] = 12'h000;
      cycle(1, d, 2'd2, 0, 0);
      d[0] = 12'h7FF;
      in_valid = 1'b1; in_data = d; in_op = 2'd0; out_ready = 1'b0;
      #1;
      check("bp_in_ready_low", in_ready, 0);
      check("bp_level_full", level, 2);
      @(negedge clk);
      cycle(1, d, 2'd0, 0, 0);
      cycle(1, d, 2'd0, 0, 1);
      check("bp_level_hold", level, 2);
      repeat (2) cycle(0, d, 2'd0, 0, 1);

      // Accumulate on ch0: 1, 1, 0, then clear with 001 -> 1
      d = '0;
      d[0] = 12'h001; cycle(1, d, 2'd3, 0, 1);
      d[0] = 12'h003; cycle(1, d, 2'd3, 0, 1);
      d[0] = 12'h007; cycle(1, d, 2'd3, 0, 1);
      d[0] = 12'h001; cycle(1, d, 2'd3, 1, 1);
      cycle(0, d, 2'd0, 0, 1);

      // X/Z on ch2
      d = '0; d[0] = 12'h001; d[1] = 12'h003;
      d[2] = 12'b0000_0000_0x01;
      cycle(1, d, 2'd1, 0, 1);
      d[2] = 12'h001; cycle(1, d, 2'd3, 0, 1);
      d[2] = 12'b0000_0000_0x01; cycle(1, d, 2'd3, 0, 1);
      d[2] = 12'h001; cycle(1, d, 2'd3, 0, 1);
      cycle(0, d, 2'd0, 0, 1);

      // Reset mid-operation with level=2 and nonzero accumulators
      d = '0; d[0] = 12'h001; d[1] = 12'h001; d[2] = 12'h001; d[3] = 12'h001;
      cycle(1, d, 2'd3, 0, 0);
      cycle(1, d, 2'd3, 0, 0);
      check("pre_rst_level", level, 2);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_out_bit", out_bit, 0);
      check("mid_rst_out_op", out_op, 0);
      check("mid_rst_in_ready", in_ready, 1);
      sb.delete();
      model_acc = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, d, 2'd3, 0, 1);
      check("post_rst_bits", out_bit, 4'b1111);
      cycle(0, d, 2'd0, 0, 1);

      // Random streaming with random consumer backpressure
      n_acc = 0;
      for (int i = 0; i < 1000 && n_acc < 100; i++) begin
         for (int c = 0; c < CH; c++) d[c] = W'($urandom());
         cycle(($urandom_range(0, 9) < 8), d, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1);
      end
      check("stream_accepted", n_acc, 100);
      for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(0, d, 2'd0, 0, 1);
      check("drain_out_valid", out_valid, 0);
      check("drain_level", level, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
